mod_n_updown_counter: RTL and testbench



---
 rtl/mod_n_pkg.sv | 14 +
 rtl/mod_n_tc_detect.sv | 31 +++
 rtl/mod_n_updown_counter.sv | 119 +++++++++++
 tb/tb_mod_n_updown_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_n_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
// Direction encoding for M and the terminal-value helper used by the
// terminal-count detector and the next-state mux.
package mod_n_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Terminal value for a direction: MODULUS-1 when counting up, 0 when counting down.
    function automatic int unsigned tc_value(input logic dir, input int unsigned modulus);
        return (dir == DIR_UP) ? (modulus - 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/mod_n_tc_detect.sv
// Terminal-count detector for mod_n_updown_counter.
// Purely combinational: TC flags the terminal value for the current direction,
// Qcc_n is the active-low carry/borrow a cascaded stage can invert into its EN.
// Comparison is done one bit wider than Q so MODULUS == 2**WIDTH is handled.
module mod_n_tc_detect
    import mod_n_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 8
) (
    input  logic [WIDTH-1:0] Q,
    input  logic             M,
    input  logic             EN,
    output logic             TC,
    output logic             Qcc_n
);

    localparam logic [WIDTH:0] TC_UP = (WIDTH + 1)'(tc_value(DIR_UP, MODULUS));
    localparam logic [WIDTH:0] TC_DN = (WIDTH + 1)'(tc_value(DIR_DN, MODULUS));

    logic [WIDTH:0] q_ext;

    assign q_ext = {1'b0, Q};

    // Terminal count follows M immediately; carry/borrow is gated by the enable.
    always_comb begin
        TC    = (M == DIR_UP) ? (q_ext == TC_UP) : (q_ext == TC_DN);
        Qcc_n = ~(EN & TC);
    end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Parametrised synchronous up/down modulo-N counter.
// Priority at each CP edge: reset > LD > EN > hold. Out-of-range loads land on 0.
// ONESHOT=1 saturates at the terminal value instead of wrapping; Qcc_n stays low
// while parked there with EN=1.
// Optional macro MOD_N_WRAP_COUNT_EN adds an 8-bit saturating WRAPS counter that
// counts genuine wrap events and is cleared by reset or LD.
module mod_n_updown_counter
    import mod_n_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 8,
    parameter int unsigned ONESHOT = 0
) (
    input  logic             CP,
    input  logic             reset,
    input  logic             EN,
    input  logic             M,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
`ifdef MOD_N_WRAP_COUNT_EN
    output logic [7:0]       WRAPS,
`endif
    output logic             Qcc_n
);

    if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
        $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(tc_value(DIR_UP, MODULUS));
    localparam logic             SATURATE = (ONESHOT != 0);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc;
    logic             load_ok;

    mod_n_tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_detect (
        .Q     (count_q),
        .M     (M),
        .EN    (EN),
        .TC    (tc),
        .Qcc_n (Qcc_n)
    );

    // Widened compare so a load is range-checked even when MODULUS == 2**WIDTH.
    assign load_ok = ({1'b0, D} < MOD_EXT);

    // Next count: load, then enabled count; +/-1 only happens off-terminal so it cannot overflow.
    always_comb begin
        count_d = count_q;
        if (LD) begin
            count_d = load_ok ? D : '0;
        end else if (EN) begin
            if (M == DIR_UP) begin
                if (tc) begin
                    count_d = SATURATE ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (tc) begin
                    count_d = SATURATE ? count_q : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge CP) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Q = count_q;

`ifdef MOD_N_WRAP_COUNT_EN
    logic [7:0] wraps_q;
    logic [7:0] wraps_d;
    logic       wrap_event;

    // A wrap only happens when not saturating; LD and reset take priority.
    assign wrap_event = EN & tc & ~LD & ~SATURATE;

    // Saturating wrap tally, cleared by a load.
    always_comb begin
        wraps_d = wraps_q;
        if (LD) begin
            wraps_d = '0;
        end else if (wrap_event && (wraps_q != 8'hFF)) begin
            wraps_d = wraps_q + 8'd1;
        end
    end

    // Wrap tally register with synchronous reset.
    always_ff @(posedge CP) begin
        if (reset) begin
            wraps_q <= '0;
        end else begin
            wraps_q <= wraps_d;
        end
    end

    assign WRAPS = wraps_q;
`else
    // No wrap tally: tc only steers the next-state mux.
`endif

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench for mod_n_updown_counter.
// Three instances share one stimulus stream: mod-8 wrapping (WIDTH=4), mod-10
// saturating (WIDTH=4, ONESHOT=1) and mod-8 in a full 3-bit range (WIDTH=3).
// Expected values come from an arithmetic model of the counting rules.
module tb_mod_n_updown_counter;

    logic       CP    = 1'b0;
    logic       reset = 1'b0;
    logic       EN    = 1'b0;
    logic       M     = 1'b0;
    logic       LD    = 1'b0;
    logic [3:0] D     = 4'd0;

    logic [3:0] q_dut;
    logic [3:0] q_one;
    logic [2:0] q_full;
    logic       qcc_dut;
    logic       qcc_one;
    logic       qcc_full;
`ifdef MOD_N_WRAP_COUNT_EN
    logic [7:0] wr_dut;
    logic [7:0] wr_one;
    logic [7:0] wr_full;
`endif

    int checks = 0;
    int errors = 0;

    int mods[3]  = '{8, 10, 8};
    bit ones[3]  = '{1'b0, 1'b1, 1'b0};
    int dmask[3] = '{15, 15, 7};
    int mq[3]    = '{0, 0, 0};
    int mw[3]    = '{0, 0, 0};
    bit mvalid   = 1'b0;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(8), .ONESHOT(0)) u_dut (
        .CP    (CP),
        .reset (reset),
        .EN    (EN),
        .M     (M),
        .LD    (LD),
        .D     (D),
        .Q     (q_dut),
`ifdef MOD_N_WRAP_COUNT_EN
        .WRAPS (wr_dut),
`endif
        .Qcc_n (qcc_dut)
    );

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1)) u_one (
        .CP    (CP),
        .reset (reset),
        .EN    (EN),
        .M     (M),
        .LD    (LD),
        .D     (D),
        .Q     (q_one),
`ifdef MOD_N_WRAP_COUNT_EN
        .WRAPS (wr_one),
`endif
        .Qcc_n (qcc_one)
    );

    mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .ONESHOT(0)) u_full (
        .CP    (CP),
        .reset (reset),
        .EN    (EN),
        .M     (M),
        .LD    (LD),
        .D     (D[2:0]),
        .Q     (q_full),
`ifdef MOD_N_WRAP_COUNT_EN
        .WRAPS (wr_full),
`endif
        .Qcc_n (qcc_full)
    );

    always #5 CP = ~CP;

    function automatic bit at_term(int q, int mod, bit m);
        return m ? (q == mod - 1) : (q == 0);
    endfunction

    function automatic int step_q(int q, int mod, bit one, bit r, bit ld, int d, bit en, bit m);
        if (r) return 0;
        if (ld) return (d < mod) ? d : 0;
        if (!en) return q;
        if (one && at_term(q, mod, m)) return q;
        if (m) return (q + 1) % mod;
        return (q + mod - 1) % mod;
    endfunction

    function automatic int step_w(int w, int q, int mod, bit one, bit r, bit ld, bit en, bit m);
        if (r || ld) return 0;
        if (en && !one && at_term(q, mod, m)) return (w < 255) ? w + 1 : 255;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit ld, input bit en, input bit m, input logic [3:0] d);
        logic [31:0] oq[3];
        logic [31:0] oc[3];
        logic [31:0] ow[3];
        reset = r;
        LD    = ld;
        EN    = en;
        M     = m;
        D     = d;
        #1;
        oc[0] = 32'(qcc_dut);
        oc[1] = 32'(qcc_one);
        oc[2] = 32'(qcc_full);
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("qcc%0d", i), oc[i],
                    32'(!(en && at_term(mq[i], mods[i], m))));
            end
        end
        @(posedge CP);
        for (int i = 0; i < 3; i++) begin
            mw[i] = step_w(mw[i], mq[i], mods[i], ones[i], r, ld, en, m);
            mq[i] = step_q(mq[i], mods[i], ones[i], r, ld, int'(d) & dmask[i], en, m);
        end
        if (r) mvalid = 1'b1;
        #1;
        oq[0] = 32'(q_dut);
        oq[1] = 32'(q_one);
        oq[2] = 32'(q_full);
`ifdef MOD_N_WRAP_COUNT_EN
        ow[0] = 32'(wr_dut);
        ow[1] = 32'(wr_one);
        ow[2] = 32'(wr_full);
`else
        ow[0] = 32'(mw[0]);
        ow[1] = 32'(mw[1]);
        ow[2] = 32'(mw[2]);
`endif
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("q%0d", i), oq[i], 32'(mq[i]));
`ifdef MOD_N_WRAP_COUNT_EN
                chk($sformatf("wraps%0d", i), ow[i], 32'(mw[i]));
`endif
            end
        end
    endtask

    initial begin
        bit r;
        bit ld;
        bit en;
        bit m;
        logic [3:0] d;

        // Reset held for two edges.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("rst_q", 32'(q_dut), 32'd0);
        chk("rst_q_one", 32'(q_one), 32'd0);

        // Count up through the wrap: 1..7,0,1,2; mod-10 oneshot parks at 9.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        chk("up_wrap", 32'(q_dut), 32'd2);
        chk("one_sat", 32'(q_one), 32'd9);
        chk("one_sat_qcc", 32'(qcc_one), 32'd0);

        // Disable while saturated: carry released.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("one_en_off_qcc", 32'(qcc_one), 32'd1);

        // Count down through the borrow: 1,0,7,6.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("down_borrow", 32'(q_dut), 32'd6);

        // Load 3 beats EN, count up to 5, flip down, reset mid-count, resume.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
        chk("load3", 32'(q_dut), 32'd3);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        chk("at5", 32'(q_dut), 32'd5);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("flip_down", 32'(q_dut), 32'd3);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("mid_reset", 32'(q_dut), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        chk("resume", 32'(q_dut), 32'd1);

        // Out-of-range load normalises to 0; full-range instance takes D[2:0]=4.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
        chk("load_oor", 32'(q_dut), 32'd0);
        chk("load_oor_one", 32'(q_one), 32'd0);
        chk("load_full", 32'(q_full), 32'd4);

        // Randomised traffic with direction runs.
        m = 1'b1;
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            ld = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) m = ~m;
            d  = 4'($urandom_range(0, 15));
            cycle(r, ld, en, m, d);
        end

`ifdef MOD_N_WRAP_COUNT_EN
        // 300 full up-cycles saturate the wrap tally; a load clears it.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 300 * 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        chk("wraps_sat", 32'(wr_dut), 32'd255);
        chk("wraps_one", 32'(wr_one), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        chk("wraps_clr", 32'(wr_dut), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
